// File: rtl/avr_hvpp_sequencer.sv
// AVR high-voltage parallel programming sequencer for the TOP2049 ZIF
// socket (Tiny26 DIP20 layout): XTAL loads, WR/RDY programming, OE reads.
module avr_hvpp_sequencer #(
  parameter int XTAL_CYCLES = 4,
  parameter int WR_CYCLES   = 4,
  parameter int OE_CYCLES   = 4,
  parameter int RDY_SETTLE  = 8,
  parameter int RDY_TIMEOUT = 24000000,
  parameter int TO_WIDTH    = 25
) (
  input  logic        osc_in,
  input  logic        rst,
  inout  wire  [7:0]  data,
  input  logic        ale,
  input  logic        write,
  input  logic        read,
  inout  wire  [48:1] zif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XTAL_HI, S_WR_LO,
    S_RDY_SET, S_RDY_WAIT, S_OE_LO, S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD, OP_PROG, OP_READ
  } op_t;

  localparam logic [TO_WIDTH-1:0] ONE     = TO_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0] XT_LAST = TO_WIDTH'(XTAL_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] WR_LAST = TO_WIDTH'(WR_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] OE_LAST = TO_WIDTH'(OE_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] RS_LAST = TO_WIDTH'(RDY_SETTLE - 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(RDY_TIMEOUT - 1);

  logic [2:0]          ale_s, wr_s;
  logic [1:0]          rdy_s;
  logic [7:0]          addr, wr_data;
  logic                evt;
  state_t              state, state_n;
  op_t                 op, op_n;
  logic [TO_WIDTH-1:0] cnt, cnt_n;
  logic                oe, oe_n, wr, wr_n, xtal, xtal_n;
  logic                xa0, xa0_n, xa1, xa1_n, bs1, bs1_n;
  logic [7:0]          dreg, dreg_n, rdata, rdata_n;
  logic                timeout, timeout_n, overrun, overrun_n;

  logic       is_cmd, is_dir, is_dat, busy, drive;
  logic [7:0] pins, status, rd_val;
  logic [48:1] zo, ze;

  assign pins = {zif[12], zif[13], zif[14], zif[15],
                 zif[18], zif[19], zif[20], zif[21]};

  assign is_cmd = evt & (addr == 8'h11 || addr == 8'h13 ||
                         addr == 8'h14);
  assign is_dir = evt & (addr == 8'h12);
  assign is_dat = evt & (addr == 8'h10);
  assign busy   = (state != S_IDLE);
  assign status = {4'b0, overrun, timeout, busy, rdy_s[1]};

  // Data pins stay released around the OE strobe of a read.
  assign drive = oe & ~(op == OP_READ &&
                        (state == S_SETUP || state == S_HOLD));

  always_ff @(posedge osc_in or posedge rst) begin
    if (rst) begin
      ale_s   <= '0;
      wr_s    <= '0;
      rdy_s   <= '0;
      addr    <= '0;
      wr_data <= '0;
      evt     <= 1'b0;
      state   <= S_IDLE;
      op      <= OP_LOAD;
      cnt     <= '0;
      oe      <= 1'b1;
      wr      <= 1'b1;
      xtal    <= 1'b0;
      xa0     <= 1'b0;
      xa1     <= 1'b0;
      bs1     <= 1'b0;
      dreg    <= '0;
      rdata   <= '0;
      timeout <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ale_s <= {ale_s[1:0], ale};
      wr_s  <= {wr_s[1:0], write};
      rdy_s <= {rdy_s[0], zif[36]};
      if (ale_s[2] & ~ale_s[1])
        addr <= data;
      if (wr_s[1] & ~wr_s[2])
        wr_data <= data;
      evt     <= wr_s[1] & ~wr_s[2];
      state   <= state_n;
      op      <= op_n;
      cnt     <= cnt_n;
      oe      <= oe_n;
      wr      <= wr_n;
      xtal    <= xtal_n;
      xa0     <= xa0_n;
      xa1     <= xa1_n;
      bs1     <= bs1_n;
      dreg    <= dreg_n;
      rdata   <= rdata_n;
      timeout <= timeout_n;
      overrun <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op;
    cnt_n     = cnt;
    oe_n      = oe;
    wr_n      = wr;
    xtal_n    = xtal;
    xa0_n     = xa0;
    xa1_n     = xa1;
    bs1_n     = bs1;
    dreg_n    = dreg;
    rdata_n   = rdata;
    timeout_n = timeout;
    overrun_n = overrun;
    if (is_dat)
      dreg_n = wr_data;
    if ((is_cmd | is_dir) && busy)
      overrun_n = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (is_cmd) begin
          state_n   = S_SETUP;
          cnt_n     = '0;
          timeout_n = 1'b0;
          overrun_n = 1'b0;
          if (addr == 8'h11) begin
            op_n  = OP_LOAD;
            xa0_n = wr_data[0];
            // XA1 and BS2 share one socket pin.
            xa1_n = wr_data[1] | wr_data[3];
            bs1_n = wr_data[2];
          end else begin
            op_n  = (addr == 8'h13) ? OP_PROG : OP_READ;
            bs1_n = wr_data[0];
            xa1_n = wr_data[1];
          end
        end else if (is_dir) begin
          case (wr_data[6:0])
            7'd2:        oe_n   = wr_data[7];
            7'd3:        wr_n   = wr_data[7];
            7'd4, 7'd9:  bs1_n  = wr_data[7];
            7'd5:        xa0_n  = wr_data[7];
            7'd6, 7'd10: xa1_n  = wr_data[7];
            7'd7:        xtal_n = wr_data[7];
            default: ;
          endcase
        end
      end
      S_SETUP: begin
        unique case (op)
          OP_LOAD: begin
            state_n = S_XTAL_HI;
            xtal_n  = 1'b1;
          end
          OP_PROG: begin
            state_n = S_WR_LO;
            wr_n    = 1'b0;
          end
          default: begin
            state_n = S_OE_LO;
            oe_n    = 1'b0;
          end
        endcase
      end
      S_XTAL_HI: begin
        if (cnt == XT_LAST) begin
          state_n = S_HOLD;
          xtal_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_WR_LO: begin
        if (cnt == WR_LAST) begin
          state_n = (RDY_SETTLE == 0) ? S_RDY_WAIT : S_RDY_SET;
          wr_n    = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_RDY_SET: begin
        if (cnt == RS_LAST) begin
          state_n = S_RDY_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_RDY_WAIT: begin
        if (rdy_s[1]) begin
          state_n = S_HOLD;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n   = S_HOLD;
          timeout_n = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_OE_LO: begin
        if (cnt == OE_LAST) begin
          state_n = S_HOLD;
          rdata_n = pins;
          oe_n    = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_HOLD: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    zo      = '0;
    ze      = '1;
    ze[36]  = 1'b0;
    ze[37]  = 1'b0;
    zo[16]  = 1'b1;
    zo[32]  = 1'b1;
    zo[28]  = wr;
    zo[29]  = xa0;
    zo[30]  = xa1;
    zo[31]  = bs1;
    zo[34]  = xtal;
    zo[35]  = oe;
    zo[21]  = dreg[0];
    zo[20]  = dreg[1];
    zo[19]  = dreg[2];
    zo[18]  = dreg[3];
    zo[15]  = dreg[4];
    zo[14]  = dreg[5];
    zo[13]  = dreg[6];
    zo[12]  = dreg[7];
    ze[21:18] = {4{drive}};
    ze[15:12] = {4{drive}};
  end

  for (genvar g = 1; g <= 48; g++) begin : g_zif
    assign zif[g] = ze[g] ? zo[g] : 1'bz;
  end

  always_comb begin
    rd_val = '0;
    case (addr[3:0])
      4'h0: rd_val = rdata;
      4'h2: rd_val = status;
      4'h6: rd_val = zif[8:1];
      4'h7: rd_val = zif[16:9];
      4'h8: rd_val = zif[24:17];
      4'h9: rd_val = zif[32:25];
      4'hA: rd_val = zif[40:33];
      4'hB: rd_val = zif[48:41];
      default: ;
    endcase
  end

  assign data = (!read && addr[4]) ? rd_val : 8'bz;

endmodule

// File: tb/tb_avr_hvpp_sequencer.sv
// Randomised bench for avr_hvpp_sequencer with an AVR pin model and a
// register-level reference model.
module tb_avr_hvpp_sequencer;

  localparam int XT = 4;
  localparam int WRC = 4;
  localparam int OEC = 4;
  localparam int TO = 50;
  localparam int NEVER = 200;

  logic osc_in = 1'b0;
  logic rst = 1'b1;
  logic ale = 1'b0;
  logic write = 1'b0;
  logic read = 1'b1;
  logic [7:0] hd = '0;
  logic hd_en = 1'b0;
  wire  [7:0] data;
  wire  [48:1] zif;

  logic rdy = 1'b1;
  logic chip_drv = 1'b0;
  logic [7:0] chip_val = '0;
  int rdy_delay = 10;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_dreg = '0, m_rdata = '0;
  logic m_xa0 = 0, m_xa1 = 0, m_bs1 = 0, m_to = 0, m_ov = 0;
  int xq[$], wq[$], oq[$];

  wire [7:0] dpins = {zif[12], zif[13], zif[14], zif[15],
                      zif[18], zif[19], zif[20], zif[21]};

  assign data = hd_en ? hd : 8'bz;
  assign zif[36] = rdy;
  assign zif[21] = chip_drv ? chip_val[0] : 1'bz;
  assign zif[20] = chip_drv ? chip_val[1] : 1'bz;
  assign zif[19] = chip_drv ? chip_val[2] : 1'bz;
  assign zif[18] = chip_drv ? chip_val[3] : 1'bz;
  assign zif[15] = chip_drv ? chip_val[4] : 1'bz;
  assign zif[14] = chip_drv ? chip_val[5] : 1'bz;
  assign zif[13] = chip_drv ? chip_val[6] : 1'bz;
  assign zif[12] = chip_drv ? chip_val[7] : 1'bz;

  avr_hvpp_sequencer #(
    .XTAL_CYCLES(XT),
    .WR_CYCLES(WRC),
    .OE_CYCLES(OEC),
    .RDY_SETTLE(8),
    .RDY_TIMEOUT(TO),
    .TO_WIDTH(8)
  ) dut (
    .osc_in(osc_in),
    .rst(rst),
    .data(data),
    .ale(ale),
    .write(write),
    .read(read),
    .zif(zif)
  );

  always #5 osc_in = ~osc_in;

  // AVR model: RDY drops during WR low and returns rdy_delay cycles
  // after WR release; data is driven while OE is low.
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(negedge osc_in);
      chip_drv = ~zif[35];
      if (!zif[28]) begin
        rdy = 1'b0;
        rc = rdy_delay;
      end else if (rc > 0) begin
        rc--;
        if (rc == 0) rdy = 1'b1;
      end
    end
  end

  initial begin
    int xr, wl, ol;
    xr = 0; wl = 0; ol = 0;
    forever begin
      @(negedge osc_in);
      if (rst) begin
        xr = 0; wl = 0; ol = 0;
      end else begin
        if (zif[34]) xr++;
        else if (xr > 0) begin xq.push_back(xr); xr = 0; end
        if (!zif[28]) wl++;
        else if (wl > 0) begin wq.push_back(wl); wl = 0; end
        if (!zif[35]) ol++;
        else if (ol > 0) begin oq.push_back(ol); ol = 0; end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge osc_in);
  endtask

  task automatic set_addr(input logic [7:0] a);
    hd = a; hd_en = 1'b1; ale = 1'b1;
    cyc(5);
    ale = 1'b0;
    cyc(5);
    hd_en = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] v);
    set_addr(a);
    hd = v; hd_en = 1'b1; write = 1'b1;
    cyc(5);
    hd_en = 1'b0; write = 1'b0;
    cyc(5);
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] v);
    set_addr(a);
    read = 1'b0;
    cyc(1);
    v = data;
    read = 1'b1;
    cyc(1);
  endtask

  task automatic wait_idle(output logic [7:0] fin, output bit sb,
                           output bit s6);
    logic [7:0] st;
    bit done;
    sb = 0; s6 = 0; done = 0; st = '0;
    set_addr(8'h12);
    read = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      st = data;
      if (st[1]) sb = 1;
      if (st == 8'h06) s6 = 1;
      if (!st[1]) begin done = 1; break; end
    end
    if (!done) chk("idle_bound", 0, 1);
    read = 1'b1;
    cyc(1);
    fin = st;
  endtask

  task automatic check_pins;
    chk("xa0", zif[29], m_xa0);
    chk("xa1_bs2", zif[30], m_xa1);
    chk("bs1", zif[31], m_bs1);
    chk("oe", zif[35], 1);
    chk("wr", zif[28], 1);
    chk("xtal", zif[34], 0);
    chk("dpins", dpins, m_dreg);
    chk("pin16", zif[16], 1);
  endtask

  task automatic check_pulses(input int nx, input int nw, input int no);
    chk("xtal_cnt", xq.size(), nx);
    if (xq.size() > 0) chk("xtal_w", xq[0], XT);
    chk("wr_cnt", wq.size(), nw);
    if (wq.size() > 0) chk("wr_w", wq[0], WRC);
    chk("oe_cnt", oq.size(), no);
    if (oq.size() > 0) chk("oe_w", oq[0], OEC);
  endtask

  task automatic wait_rdy;
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (rdy) begin ok = 1; break; end
    end
    if (!ok) chk("rdy_bound", 0, 1);
    cyc(4);
  endtask

  // kind: 0 data reg, 1 XTAL load, 2 WR program, 3 read, 4 direct pin
  task automatic run_cmd(input int kind, input logic [7:0] v,
                         input int d);
    logic [7:0] fin, r;
    bit sb, s6;
    xq.delete(); wq.delete(); oq.delete();
    case (kind)
      0: begin
        host_write(8'h10, v);
        m_dreg = v;
      end
      1: begin
        host_write(8'h11, v);
        m_xa0 = v[0]; m_xa1 = v[1] | v[3]; m_bs1 = v[2];
        m_to = 0; m_ov = 0;
      end
      2: begin
        rdy_delay = d;
        host_write(8'h13, v);
        m_bs1 = v[0]; m_xa1 = v[1];
        m_to = (d >= NEVER); m_ov = 0;
      end
      3: begin
        chip_val = 8'(d);
        host_write(8'h14, v);
        m_bs1 = v[0]; m_xa1 = v[1];
        m_rdata = 8'(d);
        m_to = 0; m_ov = 0;
      end
      default: begin
        host_write(8'h12, v);
        if (v[6:0] == 4 || v[6:0] == 9) m_bs1 = v[7];
        if (v[6:0] == 5) m_xa0 = v[7];
        if (v[6:0] == 6 || v[6:0] == 10) m_xa1 = v[7];
      end
    endcase
    wait_idle(fin, sb, s6);
    if (kind == 2 && m_to) chk("to_busy_06", s6, 1);
    if (kind == 2 && d >= 30) chk("busy_seen", sb, 1);
    chk("status", fin, {4'b0, m_ov, m_to, 1'b0, rdy});
    check_pins();
    check_pulses(kind == 1, kind == 2, kind == 3);
    if (kind == 3) begin
      host_read(8'h10, r);
      chk("rdata", r, m_rdata);
    end
    if (m_to) wait_rdy();
  endtask

  initial begin
    logic [7:0] fin, r;
    bit sb, s6, hit;
    int kind, d;
    logic [7:0] v;
    int sels[5];
    sels = '{4, 5, 6, 9, 10};

    cyc(3);
    chk("rst_oe", zif[35], 1);
    chk("rst_wr", zif[28], 1);
    chk("rst_xtal", zif[34], 0);
    chk("rst_dpins", dpins, 8'h00);
    chk("rst_pin32", zif[32], 1);
    rst = 1'b0;
    cyc(3);
    wait_idle(fin, sb, s6);
    chk("rst_status", fin, {7'b0, rdy});
    check_pins();

    run_cmd(0, 8'hA5, 0);
    run_cmd(1, 8'h05, 0);
    run_cmd(2, 8'h00, 30);
    run_cmd(2, 8'h00, NEVER);
    run_cmd(1, 8'h00, 0);
    run_cmd(3, 8'h02, 8'h3C);

    // Pin write while a WR program is still busy must be dropped.
    xq.delete(); wq.delete(); oq.delete();
    rdy_delay = 40;
    host_write(8'h13, 8'h00);
    host_write(8'h12, 8'h87);
    m_bs1 = 0; m_xa1 = 0; m_to = 0; m_ov = 1;
    wait_idle(fin, sb, s6);
    chk("ovr_status", fin, {4'b0, m_ov, m_to, 1'b0, rdy});
    chk("ovr_xtal", xq.size(), 0);
    check_pins();
    run_cmd(1, 8'h00, 0);

    // Asynchronous reset in the middle of the XTAL pulse.
    xq.delete();
    fork
      host_write(8'h11, 8'h0F);
      begin
        hit = 0;
        for (int i = 0; i < 40; i++) begin
          cyc(1);
          if (zif[34]) begin hit = 1; break; end
        end
        chk("xtal_rise", hit, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_xtal", zif[34], 0);
        chk("arst_oe", zif[35], 1);
        chk("arst_wr", zif[28], 1);
        chk("arst_dpins", dpins, 8'h00);
        cyc(8);
        rst = 1'b0;
      end
    join
    m_dreg = 0; m_rdata = 0;
    m_xa0 = 0; m_xa1 = 0; m_bs1 = 0; m_to = 0; m_ov = 0;
    cyc(5);
    wait_idle(fin, sb, s6);
    chk("arst_status", fin, {7'b0, rdy});
    check_pins();
    host_read(8'h10, r);
    chk("arst_rdata", r, 8'h00);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      v = 8'($urandom);
      d = 0;
      if (kind == 2)
        d = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(1, 40);
      if (kind == 3) d = $urandom_range(0, 255);
      if (kind == 4) v = {v[7], 7'(sels[$urandom_range(0, 4)])};
      run_cmd(kind, v, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
